interframe_space: RTL

- Interframe-space controller for the CAN framemaker.
- Consumes end-of-EOF and end-of-delimiter events, then runs bus integration, intermission, bus-idle and start-of-frame detection.
- Decides when an overload frame starts and drives isOverload into the overload stage. It returns to intermission when that stage reports endOverload.
- All logic advances once per bit, on the samplePoint edge.

---
 rtl/interframe_space.sv | 131 +++++++++++++
 1 files changed

// File: rtl/interframe_space.sv
// CAN interframe-space controller: bus integration, intermission, bus-idle and SOF detection,
// and overload-frame launch. Everything advances once per bit on the samplePoint edge.
module interframe_space #(
    parameter int IDLE_BITS         = 11,
    parameter int INTERMISSION_BITS = 3,
    parameter int MAX_OVERLOADS     = 2
) (
    input  logic       samplePoint,
    input  logic       reset,
    input  logic       canRX,
    input  logic       eofDone,
    input  logic       delimDone,
    input  logic       overloadReq,
    input  logic       isError,
    input  logic       endOverload,
    output logic       isOverload,
    output logic       startOfFrame,
    output logic       busIdle,
    output logic [1:0] ovlCount
);

    localparam int CNT_W = $clog2(IDLE_BITS + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_BITS - 1);
    localparam logic [CNT_W-1:0] INTER_LAST = CNT_W'(INTERMISSION_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]       OVL_MAX    = 2'(MAX_OVERLOADS);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        WAIT,
        INTER,
        OVLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ovl_q, ovl_d;
    logic             sof_q, sof_d;
    logic             idle_q, idle_d;
    logic             isovl_q, isovl_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovl_d   = ovl_q;
        sof_d   = 1'b0;

        if (state_q == SYNC) begin
            // Integration ignores all frame events; only recessive runs matter.
            if (!canRX) begin
                cnt_d = '0;
            end else if (cnt_q == IDLE_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (isError) begin
            state_d = WAIT;
        end else begin
            case (state_q)
                WAIT: begin
                    if (eofDone || delimDone) begin
                        state_d = INTER;
                        cnt_d   = '0;
                    end
                end
                OVLD: begin
                    if (delimDone || endOverload) begin
                        state_d = INTER;
                        cnt_d   = '0;
                    end
                end
                IDLE: begin
                    if (!canRX) begin
                        state_d = WAIT;
                        sof_d   = 1'b1;
                    end
                end
                INTER: begin
                    // Reactive overload outranks a local request at bit 0.
                    if (!canRX && (cnt_q <= CNT_ONE)) begin
                        state_d = OVLD;
                    end else if (overloadReq && (cnt_q == '0) && (ovl_q < OVL_MAX)) begin
                        state_d = OVLD;
                        ovl_d   = ovl_q + 2'd1;
                    end else if (cnt_q == INTER_LAST) begin
                        ovl_d = '0;
                        if (canRX) begin
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT;
                            sof_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        idle_d  = (state_d == IDLE);
        isovl_d = (state_d == OVLD);
    end

    always_ff @(posedge samplePoint) begin
        if (reset) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            ovl_q   <= '0;
            sof_q   <= 1'b0;
            idle_q  <= 1'b0;
            isovl_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovl_q   <= ovl_d;
            sof_q   <= sof_d;
            idle_q  <= idle_d;
            isovl_q <= isovl_d;
        end
    end

    assign isOverload   = isovl_q;
    assign startOfFrame = sof_q;
    assign busIdle      = idle_q;
    assign ovlCount     = ovl_q;

endmodule
